// File: rtl/column_move_collector.sv
// column_move_collector
//   Collects encoded moves from the eight cell units of one board column.
//   A round-robin arbiter accepts at most one move per cycle into a
//   first-word-fall-through FIFO. The FIFO drains to the move list over a
//   valid/ready handshake. The per-cell done flags are combined into a
//   column done flag that is raised once the column has fully drained.
//
// Ports
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   newboard    synchronous flush at the start of a new board evaluation
//   cell_req    per-cell move request, held with its data until granted
//   cell_move   per-cell move word, cell i at [i*MOVE_W +: MOVE_W]
//   cell_done   per-cell done flags
//   cell_gnt    combinational one-hot grant; the move is written this edge
//   ml_valid    FIFO head valid
//   ml_data     FIFO head move
//   ml_ready    move list accepts the head
//   fifo_count  current occupancy, 0..DEPTH
//   move_total  moves accepted since the last newboard, saturating at 255
//   col_done    all cells done and FIFO drained; held until newboard
module column_move_collector #(
    parameter int NCELL  = 8,
    parameter int MOVE_W = 16,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    newboard,
    input  logic [NCELL-1:0]        cell_req,
    input  logic [NCELL*MOVE_W-1:0] cell_move,
    input  logic [NCELL-1:0]        cell_done,
    output logic [NCELL-1:0]        cell_gnt,
    output logic                    ml_valid,
    output logic [MOVE_W-1:0]       ml_data,
    input  logic                    ml_ready,
    output logic [AW:0]             fifo_count,
    output logic [7:0]              move_total,
    output logic                    col_done
);

    localparam int RRW = (NCELL > 1) ? $clog2(NCELL) : 1;

    logic [MOVE_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [AW:0]       r_count;
    logic [RRW-1:0]    r_rr;
    logic [7:0]        r_total;
    logic              r_col_done;

    logic              w_pop;
    logic              w_space;
    logic              w_push;
    logic [RRW-1:0]    w_gnt_idx;
    logic [AW:0]       w_count_next;
    logic [MOVE_W-1:0] w_push_data;

    assign ml_valid   = (r_count != '0);
    assign ml_data    = r_mem[r_rptr];
    assign fifo_count = r_count;
    assign move_total = r_total;
    assign col_done   = r_col_done;

    // A pop during a newboard cycle is swallowed by the flush.
    assign w_pop   = ml_valid & ml_ready & ~newboard;
    // A full FIFO still has room when the head leaves in the same cycle.
    assign w_space = (r_count < (AW+1)'(DEPTH)) | (ml_valid & ml_ready);

    // Round-robin search starting at r_rr, wrapping modulo NCELL.
    always_comb begin
        logic [RRW:0] v_sum;
        w_push    = 1'b0;
        w_gnt_idx = '0;
        cell_gnt  = '0;
        v_sum     = '0;
        if (reset_n && w_space && (|cell_req) && !newboard) begin
            for (int i = 0; i < NCELL; i++) begin
                v_sum = {1'b0, r_rr} + (RRW+1)'(i);
                if (v_sum >= (RRW+1)'(NCELL)) begin
                    v_sum = v_sum - (RRW+1)'(NCELL);
                end
                if (!w_push && cell_req[v_sum[RRW-1:0]]) begin
                    w_push    = 1'b1;
                    w_gnt_idx = v_sum[RRW-1:0];
                end
            end
        end
        if (w_push) begin
            cell_gnt[w_gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        w_push_data = '0;
        for (int i = 0; i < NCELL; i++) begin
            if (w_gnt_idx == RRW'(i)) begin
                w_push_data = cell_move[i*MOVE_W +: MOVE_W];
            end
        end
    end

    always_comb begin
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    // Storage carries no reset; only the pointers and counters do.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_rr       <= '0;
            r_total    <= '0;
            r_col_done <= 1'b0;
        end else if (newboard) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_rr       <= '0;
            r_total    <= '0;
            r_col_done <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
                r_rr   <= (w_gnt_idx == RRW'(NCELL-1)) ? '0 : w_gnt_idx + 1'b1;
                if (r_total != 8'hFF) begin
                    r_total <= r_total + 1'b1;
                end
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count <= w_count_next;
            // Sticky: a late request after done is a cell error, not a clear.
            if ((&cell_done) && !(|cell_req) && (w_count_next == '0)) begin
                r_col_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_column_move_collector.sv
module tb_column_move_collector;

    localparam int NCELL  = 8;
    localparam int MOVE_W = 16;
    localparam int DEPTH  = 16;
    localparam int AW     = 4;

    logic                    clk = 1'b0;
    logic                    reset_n;
    logic                    newboard;
    logic [NCELL-1:0]        cell_req;
    logic [NCELL*MOVE_W-1:0] cell_move;
    logic [NCELL-1:0]        cell_done;
    logic [NCELL-1:0]        cell_gnt;
    logic                    ml_valid;
    logic [MOVE_W-1:0]       ml_data;
    logic                    ml_ready;
    logic [AW:0]             fifo_count;
    logic [7:0]              move_total;
    logic                    col_done;

    always #5 clk = ~clk;

    column_move_collector #(
        .NCELL (NCELL),
        .MOVE_W(MOVE_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .newboard  (newboard),
        .cell_req  (cell_req),
        .cell_move (cell_move),
        .cell_done (cell_done),
        .cell_gnt  (cell_gnt),
        .ml_valid  (ml_valid),
        .ml_data   (ml_data),
        .ml_ready  (ml_ready),
        .fifo_count(fifo_count),
        .move_total(move_total),
        .col_done  (col_done)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: a plain queue of accepted moves plus scalar state.
    logic [MOVE_W-1:0] q[$];
    int                m_rr;
    int                m_total;
    bit                m_done;

    // Bench-side cells: remaining move count and current move per cell.
    int                pend[NCELL];
    logic [MOVE_W-1:0] mv[NCELL];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [MOVE_W-1:0] new_move(input int i);
        logic [MOVE_W-1:0] m;
        m[15]    = 1'($urandom);
        m[14:12] = 3'($urandom);
        m[11:9]  = 3'(i);
        m[8:6]   = 3'($urandom_range(1, 6));
        m[5:0]   = 6'($urandom);
        return m;
    endfunction

    function automatic bit any_pend();
        for (int i = 0; i < NCELL; i++) if (pend[i] > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive_cells();
        for (int i = 0; i < NCELL; i++) begin
            cell_req[i] = (pend[i] > 0);
            cell_move[i*MOVE_W +: MOVE_W] = mv[i];
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_rr    = 0;
        m_total = 0;
        m_done  = 1'b0;
    endtask

    // One clock: check outputs at the falling edge, then advance the model.
    task automatic cycle();
        logic [NCELL-1:0] eg;
        int  k;
        bit  pop;
        @(negedge clk);
        eg = '0;
        k  = -1;
        if (!newboard && cell_req != '0 &&
            (q.size() < DEPTH || (q.size() != 0 && ml_ready))) begin
            for (int i = 0; i < NCELL; i++) begin
                int c;
                c = (m_rr + i) % NCELL;
                if (k < 0 && cell_req[c]) k = c;
            end
        end
        if (k >= 0) eg[k] = 1'b1;
        chk("cell_gnt", 32'(cell_gnt), 32'(eg));
        chk("ml_valid", 32'(ml_valid), 32'(q.size() != 0));
        if (q.size() != 0) chk("ml_data", 32'(ml_data), 32'(q[0]));
        chk("fifo_count", 32'(fifo_count), 32'(q.size()));
        chk("move_total", 32'(move_total), 32'(m_total));
        chk("col_done", 32'(col_done), 32'(m_done));
        pop = (q.size() != 0) && ml_ready && !newboard;
        @(posedge clk);
        #1;
        if (newboard) begin
            model_reset();
        end else begin
            if (pop) void'(q.pop_front());
            if (k >= 0) begin
                q.push_back(mv[k]);
                m_rr = (k + 1) % NCELL;
                if (m_total < 255) m_total++;
                pend[k]--;
                mv[k] = new_move(k);
            end
            if ((&cell_done) && cell_req == '0 && q.size() == 0) m_done = 1'b1;
        end
        drive_cells();
    endtask

    task automatic drain(input string tag, input int budget);
        int t;
        t = 0;
        while ((any_pend() || q.size() != 0) && t < budget) begin
            cycle();
            t++;
        end
        chk(tag, 32'(fifo_count), 32'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        newboard  = 1'b0;
        cell_req  = '0;
        cell_move = '0;
        cell_done = '0;
        ml_ready  = 1'b0;
        for (int i = 0; i < NCELL; i++) begin
            pend[i] = 0;
            mv[i]   = new_move(i);
        end
        model_reset();
        drive_cells();

        // Reset state
        #1;
        chk("rst_gnt", 32'(cell_gnt), 32'(0));
        chk("rst_valid", 32'(ml_valid), 32'(0));
        chk("rst_count", 32'(fifo_count), 32'(0));
        chk("rst_total", 32'(move_total), 32'(0));
        chk("rst_done", 32'(col_done), 32'(0));
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (2) cycle();

        // Asynchronous reset in the middle of operation with 5 queued
        pend[2] = 8;
        drive_cells();
        repeat (5) cycle();
        chk("pre_rst_count", 32'(fifo_count), 32'(5));
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_gnt", 32'(cell_gnt), 32'(0));
        chk("arst_valid", 32'(ml_valid), 32'(0));
        chk("arst_count", 32'(fifo_count), 32'(0));
        chk("arst_total", 32'(move_total), 32'(0));
        chk("arst_done", 32'(col_done), 32'(0));
        for (int i = 0; i < NCELL; i++) pend[i] = 0;
        model_reset();
        drive_cells();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (2) cycle();

        // Round-robin fairness: every cell requesting twice
        newboard = 1'b1;
        cycle();
        newboard = 1'b0;
        ml_ready = 1'b1;
        for (int i = 0; i < NCELL; i++) pend[i] = 2;
        drive_cells();
        drain("rr_drain", 60);

        // Fill and backpressure from a single cell
        newboard = 1'b1;
        cycle();
        newboard = 1'b0;
        ml_ready = 1'b0;
        pend[3]  = 20;
        drive_cells();
        repeat (18) cycle();
        chk("fill_count", 32'(fifo_count), 32'(16));
        chk("fill_gnt", 32'(cell_gnt), 32'(0));
        ml_ready = 1'b1;
        cycle();
        ml_ready = 1'b0;
        chk("fill_pushpop_count", 32'(fifo_count), 32'(16));
        chk("fill_pushpop_total", 32'(move_total), 32'(17));
        ml_ready = 1'b1;
        drain("fill_drain", 100);

        // Wrap-around with random cells and random backpressure
        newboard = 1'b1;
        cycle();
        newboard = 1'b0;
        for (int n = 0; n < 40; n++) pend[$urandom_range(0, NCELL-1)]++;
        drive_cells();
        for (int t = 0; t < 600 && (any_pend() || q.size() != 0); t++) begin
            ml_ready = 1'($urandom);
            cycle();
        end
        chk("wrap_drained", 32'(fifo_count), 32'(0));
        chk("wrap_total", 32'(move_total), 32'(40));

        // newboard flush with 7 queued and rr pointer at 5
        newboard = 1'b1;
        cycle();
        newboard = 1'b0;
        ml_ready = 1'b0;
        pend[4]  = 7;
        drive_cells();
        for (int t = 0; t < 20 && pend[4] > 0; t++) cycle();
        chk("flush_pre_count", 32'(fifo_count), 32'(7));
        pend[0]  = 1;
        newboard = 1'b1;
        drive_cells();
        cycle();
        newboard = 1'b0;
        chk("flush_count", 32'(fifo_count), 32'(0));
        chk("flush_total", 32'(move_total), 32'(0));
        cycle();
        chk("flush_cell0_total", 32'(move_total), 32'(1));
        ml_ready = 1'b1;
        drain("flush_drain", 20);

        // Done aggregation
        newboard = 1'b1;
        cycle();
        newboard  = 1'b0;
        ml_ready  = 1'b0;
        cell_done = '1;
        pend[6]   = 2;
        drive_cells();
        repeat (3) cycle();
        chk("done_queued", 32'(col_done), 32'(0));
        ml_ready = 1'b1;
        cycle();
        chk("done_one_left", 32'(col_done), 32'(0));
        cycle();
        chk("done_set", 32'(col_done), 32'(1));
        cell_done = '0;
        repeat (2) cycle();
        chk("done_held", 32'(col_done), 32'(1));
        newboard = 1'b1;
        cycle();
        newboard = 1'b0;
        chk("done_cleared", 32'(col_done), 32'(0));
        repeat (2) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
